// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and defaults for the piano step-sequencer pattern controller.
//   state_e      : controller FSM states
//   *_D          : default parameter values for step_sequencer
//   STEP_IDX_W() : width of a step index for a given pattern length
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_STEPS_D = 16;
  localparam int NOTE_W_D    = 12;
  localparam int LOOP_W_D    = 8;

  // Index width for a pattern of n steps; never narrower than one bit.
  function automatic int STEP_IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/start_sync.sv
// -----------------------------------------------------------------------------
// start_sync
// Brings an active-low asynchronous push-button into the Clock domain and
// turns its falling edge into a single-cycle pulse.
//   Clock   in  : system clock
//   nReset  in  : asynchronous active-low reset
//   async_n in  : raw active-low button input, asynchronous to Clock
//   pulse   out : one-cycle high pulse per press (after two sync stages)
// The pulse is decoded combinationally from flops so a consumer that samples
// it sees the event on the third rising edge after async_n falls.
// -----------------------------------------------------------------------------
module start_sync (
  input  logic Clock,
  input  logic nReset,
  input  logic async_n,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = async_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Flops reset high so a released button does not look like a press.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // High for exactly one cycle on the synchronized 1->0 transition; holding
  // the button down keeps sync2_q low and yields no further pulses.
  assign pulse = prev_q & ~sync2_q;

endmodule

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Pattern controller for the step-sequencer audio path. Stores NUM_STEPS note
// masks, walks through them on Step pulses and counts passes.
//   Clock, nReset : clock and asynchronous active-low reset
//   nStart        : raw active-low start button (synchronized internally)
//   Stop          : one-cycle stop pulse
//   Step          : one-cycle advance pulse from the BPM counter
//   Loops         : passes per run, 0 = forever (sampled at start only)
//   wr_en/wr_addr/wr_data : pattern write port, one entry per cycle
//   Select        : note mask of the current step (0 when not playing)
//   Play          : playback active
//   step_idx      : current step index
//   loop_idx      : completed passes in the current run
//   Done          : one-cycle pulse when a run ends
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_D,
  parameter int NOTE_W    = NOTE_W_D,
  parameter int LOOP_W    = LOOP_W_D
) (
  input  logic                                 Clock,
  input  logic                                 nReset,
  input  logic                                 nStart,
  input  logic                                 Stop,
  input  logic                                 Step,
  input  logic [LOOP_W-1:0]                    Loops,
  input  logic                                 wr_en,
  input  logic [STEP_IDX_W(NUM_STEPS)-1:0]     wr_addr,
  input  logic [NOTE_W-1:0]                    wr_data,
  output logic [NOTE_W-1:0]                    Select,
  output logic                                 Play,
  output logic [STEP_IDX_W(NUM_STEPS)-1:0]     step_idx,
  output logic [LOOP_W-1:0]                    loop_idx,
  output logic                                 Done
);

  localparam int IDX_W = STEP_IDX_W(NUM_STEPS);

  logic start_evt;

  start_sync u_start_sync (
    .Clock   (Clock),
    .nReset  (nReset),
    .async_n (nStart),
    .pulse   (start_evt)
  );

  // ---------------------------------------------------------------------------
  // Pattern storage: plain register array so a same-cycle write can be
  // forwarded into the step being loaded.
  // ---------------------------------------------------------------------------
  logic [NOTE_W-1:0] pattern_q [NUM_STEPS];
  logic [NOTE_W-1:0] pattern_d [NUM_STEPS];

  always_comb begin
    pattern_d = pattern_q;
    if (wr_en) pattern_d[wr_addr] = wr_data;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern_q[i] <= '0;
    end else begin
      pattern_q <= pattern_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic [NOTE_W-1:0]  select_q,   select_d;
  logic               play_q,     play_d;
  logic [IDX_W-1:0]   step_idx_q, step_idx_d;
  logic [LOOP_W-1:0]  loop_idx_q, loop_idx_d;
  logic               done_q,     done_d;
  logic [LOOP_W-1:0]  loops_q,    loops_d;

  logic [IDX_W-1:0]   step_inc;
  logic               step_last;
  logic [IDX_W-1:0]   load_idx;
  logic [NOTE_W-1:0]  load_note;
  logic [LOOP_W-1:0]  loop_sat;

  // NUM_STEPS is a power of two, so step_idx+1 wraps to 0 on the last step;
  // the only index ever loaded is therefore 0 (start/restart) or step_inc.
  assign step_inc  = step_idx_q + 1'b1;
  assign step_last = (step_idx_q == IDX_W'(NUM_STEPS - 1));
  assign load_idx  = (state_q == PLAY && !Stop && !start_evt) ? step_inc : '0;
  // Write-through: a write landing on the index being loaded wins.
  assign load_note = (wr_en && wr_addr == load_idx) ? wr_data : pattern_q[load_idx];
  assign loop_sat  = (loop_idx_q == {LOOP_W{1'b1}}) ? loop_idx_q : loop_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    select_d   = select_q;
    play_d     = play_q;
    step_idx_d = step_idx_q;
    loop_idx_d = loop_idx_q;
    done_d     = 1'b0;
    loops_d    = loops_q;

    unique case (state_q)
      IDLE: begin
        if (start_evt && !Stop) begin
          loops_d    = Loops;
          step_idx_d = '0;
          loop_idx_d = '0;
          select_d   = load_note;
          play_d     = 1'b1;
          state_d    = PLAY;
        end
      end

      PLAY: begin
        if (Stop) begin
          state_d    = DONE;
          done_d     = 1'b1;
          play_d     = 1'b0;
          select_d   = '0;
          step_idx_d = '0;
        end else if (start_evt) begin
          loops_d    = Loops;
          step_idx_d = '0;
          loop_idx_d = '0;
          select_d   = load_note;
        end else if (Step) begin
          if (!step_last) begin
            step_idx_d = step_inc;
            select_d   = load_note;
          end else begin
            loop_idx_d = loop_sat;
            if (loops_q != '0 && loop_sat == loops_q) begin
              state_d    = DONE;
              done_d     = 1'b1;
              play_d     = 1'b0;
              select_d   = '0;
              step_idx_d = '0;
            end else begin
              step_idx_d = '0;
              select_d   = load_note;
            end
          end
        end
      end

      DONE: begin
        // Done was raised on entry; it drops here and late starts are dropped.
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        play_d     = 1'b0;
        select_d   = '0;
        step_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      select_q   <= '0;
      play_q     <= 1'b0;
      step_idx_q <= '0;
      loop_idx_q <= '0;
      done_q     <= 1'b0;
      loops_q    <= '0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      play_q     <= play_d;
      step_idx_q <= step_idx_d;
      loop_idx_q <= loop_idx_d;
      done_q     <= done_d;
      loops_q    <= loops_d;
    end
  end

  assign Select   = select_q;
  assign Play     = play_q;
  assign step_idx = step_idx_q;
  assign loop_idx = loop_idx_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
// Directed bench for step_sequencer. Each step pushes its expected output
// tuple onto a scoreboard queue before driving; the tuple is popped and
// compared field by field once the DUT has reacted.
// -----------------------------------------------------------------------------
module tb_step_sequencer;

  localparam int N  = 16;
  localparam int NW = 12;
  localparam int LW = 8;
  localparam int IW = 4;

  logic          Clock   = 1'b0;
  logic          nReset  = 1'b0;
  logic          nStart  = 1'b1;
  logic          Stop    = 1'b0;
  logic          Step    = 1'b0;
  logic [LW-1:0] Loops   = '0;
  logic          wr_en   = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [NW-1:0] wr_data = '0;
  logic [NW-1:0] Select;
  logic          Play;
  logic [IW-1:0] step_idx;
  logic [LW-1:0] loop_idx;
  logic          Done;

  step_sequencer #(.NUM_STEPS(N), .NOTE_W(NW), .LOOP_W(LW)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .nStart   (nStart),
    .Stop     (Stop),
    .Step     (Step),
    .Loops    (Loops),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .Select   (Select),
    .Play     (Play),
    .step_idx (step_idx),
    .loop_idx (loop_idx),
    .Done     (Done)
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic          play;
    logic [NW-1:0] sel;
    logic [IW-1:0] idx;
    logic [LW-1:0] lp;
    logic          done;
  } exp_t;

  exp_t          sb_q[$];
  string         tag_q[$];
  logic [NW-1:0] model_pat [N];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic play, input logic [NW-1:0] sel,
                          input int idx, input int lp, input logic done);
    exp_t e;
    e.play = play;
    e.sel  = sel;
    e.idx  = IW'(idx);
    e.lp   = LW'(lp);
    e.done = done;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_underflow: observed empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    $display("[TB] %s play=%0b sel=%03h idx=%0d loop=%0d done=%0b", t, Play, Select, step_idx, loop_idx, Done);
    chk({t, ".play"}, 32'(Play),     32'(e.play));
    chk({t, ".sel"},  32'(Select),   32'(e.sel));
    chk({t, ".idx"},  32'(step_idx), 32'(e.idx));
    chk({t, ".loop"}, 32'(loop_idx), 32'(e.lp));
    chk({t, ".done"}, 32'(Done),     32'(e.done));
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_step(input logic with_stop);
    Step = 1'b1;
    Stop = with_stop;
    cyc();
    Step = 1'b0;
    Stop = 1'b0;
  endtask

  task automatic write_pat(input int addr, input logic [NW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = IW'(addr);
    wr_data = data;
    cyc();
    wr_en   = 1'b0;
    model_pat[addr] = data;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) model_pat[i] = '0;

    // ---- reset held with Step toggling, then idle after release ----
    for (int c = 0; c < 3; c++) begin
      Step = ~Step;
      push_exp("reset", 1'b0, '0, 0, 0, 1'b0);
      cyc();
      check_out();
    end
    Step   = 1'b0;
    nReset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push_exp("idle_step", 1'b0, '0, 0, 0, 1'b0);
      do_step(1'b0);
      check_out();
    end

    // ---- basic run, Loops=2 ----
    for (int i = 0; i < N; i++) write_pat(i, NW'(1) << (i % 12));
    Loops  = 8'd2;
    nStart = 1'b0;
    cyc();
    cyc();
    push_exp("pre_start", 1'b0, '0, 0, 0, 1'b0);
    check_out();
    push_exp("start", 1'b1, 12'h001, 0, 0, 1'b0);
    cyc();
    check_out();
    nStart = 1'b1;
    Loops  = 8'd5;  // must be ignored while playing
    for (int s = 1; s <= 32; s++) begin
      if (s < 32) push_exp($sformatf("basic_s%0d", s), 1'b1, model_pat[s % N], s % N, s / N, 1'b0);
      else        push_exp("basic_end", 1'b0, '0, 0, 2, 1'b1);
      do_step(1'b0);
      check_out();
    end
    push_exp("after_done", 1'b0, '0, 0, 2, 1'b0);
    cyc();
    check_out();

    // ---- infinite loop with a rest at step 3 ----
    write_pat(3, '0);
    Loops  = 8'd0;
    nStart = 1'b0;
    cyc();
    cyc();
    push_exp("inf_start", 1'b1, model_pat[0], 0, 0, 1'b0);
    cyc();
    check_out();
    nStart = 1'b1;
    for (int s = 1; s <= 101; s++) begin
      push_exp($sformatf("inf_s%0d", s), 1'b1, model_pat[s % N], s % N, s / N, 1'b0);
      do_step(1'b0);
      check_out();
      if (s == 100) chk("inf_loop_after_100", 32'(loop_idx), 32'd6);
    end

    // ---- Stop together with Step at step 5 ----
    push_exp("stop_step", 1'b0, '0, 0, 6, 1'b1);
    do_step(1'b1);
    check_out();
    push_exp("stop_idle", 1'b0, '0, 0, 6, 1'b0);
    cyc();
    check_out();

    // ---- Stop coincident with start_evt in IDLE ----
    Loops  = 8'd1;
    nStart = 1'b0;
    cyc();
    cyc();
    Stop = 1'b1;
    push_exp("stop_vs_start", 1'b0, '0, 0, 6, 1'b0);
    cyc();
    Stop = 1'b0;
    check_out();
    for (int c = 0; c < 3; c++) begin
      push_exp("stop_vs_start_hold", 1'b0, '0, 0, 6, 1'b0);
      cyc();
      check_out();
    end
    nStart = 1'b1;
    repeat (4) cyc();

    // ---- restart mid-run, then write-through ----
    Loops  = 8'd3;
    nStart = 1'b0;
    cyc();
    cyc();
    push_exp("rs_start", 1'b1, model_pat[0], 0, 0, 1'b0);
    cyc();
    check_out();
    nStart = 1'b1;
    for (int s = 1; s <= 25; s++) begin
      push_exp($sformatf("rs_s%0d", s), 1'b1, model_pat[s % N], s % N, s / N, 1'b0);
      do_step(1'b0);
      check_out();
    end
    nStart = 1'b0;
    cyc();
    cyc();
    push_exp("restart", 1'b1, model_pat[0], 0, 0, 1'b0);
    cyc();
    check_out();
    nStart = 1'b1;

    wr_en   = 1'b1;
    wr_addr = 4'd1;
    wr_data = 12'hABC;
    model_pat[1] = 12'hABC;
    push_exp("wr_through", 1'b1, 12'hABC, 1, 0, 1'b0);
    do_step(1'b0);
    wr_en = 1'b0;
    check_out();
    push_exp("wr_cur_hold", 1'b1, 12'hABC, 1, 0, 1'b0);
    write_pat(1, 12'h123);
    check_out();
    push_exp("after_wr_step", 1'b1, model_pat[2], 2, 0, 1'b0);
    do_step(1'b0);
    check_out();

    // ---- asynchronous reset between edges ----
    @(posedge Clock);
    #5;
    nReset = 1'b0;
    #1;
    push_exp("async_rst", 1'b0, '0, 0, 0, 1'b0);
    check_out();
    for (int i = 0; i < N; i++) model_pat[i] = '0;
    @(posedge Clock);
    #1;
    nReset = 1'b1;
    cyc();
    Loops  = 8'd0;
    nStart = 1'b0;
    cyc();
    cyc();
    push_exp("clr_start", 1'b1, '0, 0, 0, 1'b0);
    cyc();
    check_out();
    nStart = 1'b1;
    for (int s = 1; s <= N; s++) begin
      push_exp($sformatf("clr_s%0d", s), 1'b1, model_pat[s % N], s % N, s / N, 1'b0);
      do_step(1'b0);
      check_out();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Pattern controller for the piano step-sequencer audio path.
- Holds a programmable pattern of NUM_STEPS note masks.
- Advances one step per Step pulse from the BPM counter, drives Select into the tone generator and Play to the output gating, and counts playback loops.
- Replaces the free-running Select/Loops wiring with a sequenced, restartable, stoppable controller.

Parameters:
- NUM_STEPS, 16, pattern length; power of two, at least 2.
- NOTE_W, 12, width of a step's note mask (one bit per semitone).
- LOOP_W, 8, width of loop-count configuration and counter.

Ports:
- Clock  in  1  system clock (50 MHz).
- nReset  in  1  asynchronous, active-low reset.
- nStart  in  1  active-low start request, raw from a push-button; asynchronous to Clock.
- Stop  in  1  synchronous one-cycle stop pulse.
- Step  in  1  synchronous one-cycle step pulse from the BPM counter.
- Loops  in  LOOP_W  number of pattern passes; 0 means loop forever.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  log2(NUM_STEPS)  pattern write index.
- wr_data  in  NOTE_W  note mask to store.
- Select  out  NOTE_W  note mask of the current step.
- Play  out  1  playback active.
- step_idx  out  log2(NUM_STEPS)  current step index.
- loop_idx  out  LOOP_W  completed passes in the current run.
- Done  out  1  one-cycle pulse when a run ends.

Behaviour:
- Reset (async, nReset=0): every pattern entry = 0, state IDLE, Select=0, Play=0, step_idx=0, loop_idx=0, Done=0, synchronizer flops=1.
- Start detection:
  - nStart passes through a 2-flop synchronizer, then a falling-edge detector.
  - start_evt is a one-cycle pulse at the 3rd rising Clock edge after nStart goes low.
  - Holding nStart low produces no further events.
- All outputs are registered.
- FSM states:
  - IDLE: Play=0, Select=0. On start_evt with no Stop in the same cycle: latch Loops into loops_q, step_idx=0, loop_idx=0, Select=pattern[0], Play=1, go to PLAY. Play is high in the cycle after start_evt.
  - PLAY: Play=1. Events are handled in this priority order (highest first):
    - Stop → go to DONE.
    - start_evt → restart: step_idx=0, loop_idx=0, Select=pattern[0], re-latch Loops.
    - Step → advance.
  - DONE: for one cycle, Done=1, Play=0, Select=0, step_idx=0. Go to IDLE on the next cycle. loop_idx holds its value until the next start.
- Advance on Step:
  - If step_idx < NUM_STEPS-1: step_idx+1, and Select=pattern[new index] in the same edge.
  - Wrap from NUM_STEPS-1: loop_idx+1 (saturating at max). If loops_q≠0 and loop_idx+1 == loops_q → go to DONE. Otherwise step_idx=0 and Select=pattern[0].
  - loops_q=0: wrap forever; loop_idx saturates at 2^LOOP_W-1.
- Rest steps: a pattern entry of 0 is a rest. Select=0 while Play stays 1.
- Pattern writes:
  - Accepted in any state, one entry per cycle.
  - A write to the currently playing index does not change Select until that index is loaded again.
  - A write and a Step in the same cycle that target the loaded index: the new data is loaded (write-through).
- Loops is sampled only at start. Changes during PLAY are ignored.
- Step and Stop are ignored in IDLE and DONE. start_evt in DONE is dropped.
- Asynchronous reset mid-run returns everything to reset values immediately. The pattern is cleared.

Decomposition:
- Package seq_pkg:
  - state enum {IDLE, PLAY, DONE}.
  - default constants NUM_STEPS_D=16, NOTE_W_D=12, LOOP_W_D=8.
  - STEP_IDX_W function (clog2).
- Sub-module start_sync: 2-flop synchronizer plus falling-edge detector. Ports Clock, nReset, async_n, pulse. Reused for other KEY inputs.
- Pattern storage is a register array inside step_sequencer. It must be an array, not a RAM macro, so that reads occur in the same cycle as the write-through.

Test Plan:
- Reset then idle: nReset low for 3 cycles, then high, with Step pulsing → Select=0, Play=0, step_idx=0, Done=0 throughout.
- Basic run, NUM_STEPS=16, Loops=2:
  - Stimulus: write pattern[i]=12'h001<<(i%12), pulse nStart low, then 32 Step pulses.
  - Play rises 3 cycles after the nStart edge, with Select=12'h001.
  - Select follows the pattern each Step.
  - loop_idx reaches 1 after Step 16.
  - On Step 32: Done pulses for one cycle, then Play=0 and Select=0.
- Infinite loop with rest, Loops=0, pattern[3]=0:
  - 100 Steps → Play stays 1.
  - Select=0 exactly while step_idx=3.
  - loop_idx=6 after Step 100.
- Stop and simultaneous events:
  - Stop and Step in the same cycle at step 5 → DONE, step_idx not advanced to 6.
  - Stop coincident with start_evt in IDLE → stays IDLE.
- Restart and writes:
  - nStart edge mid-run at step 9 → step_idx=0, loop_idx=0, Select=pattern[0].
  - Write pattern[1]=12'hABC coincident with the Step from 0→1 → Select=12'hABC.
- Async reset mid-run: assert nReset during PLAY between Clock edges → Play=0 and Select=0 before the next edge; after release the pattern reads as all zero.
